deserializer: RTL

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/deserializer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel word assembler (LSB first) feeding a 2-entry output FIFO.
// Define DESERIALIZER_PARITY_EN to expect and check one even-parity bit after each word.
module deserializer #(
  parameter int LENGTH = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_din_valid,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid,
  input  logic              i_dout_ready,
  output logic              o_overflow,
  output logic              o_parity_err
);

  // state    | meaning
  // S_IDLE   | counter 0, waiting for bit 0 of a word
  // S_SHIFT  | bits 1..LENGTH-1 in progress
  // S_PARITY | word complete, waiting for its parity bit (parity builds only)

  localparam int CW = $clog2(LENGTH + 1);

`ifdef DESERIALIZER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_t;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LENGTH-1:0] shift_q, shift_d;
  logic [LENGTH-1:0] push_word;
  logic              push;
  logic              capture;
`ifdef DESERIALIZER_PARITY_EN
  logic              perr_q, perr_d;
`endif

  logic [LENGTH-1:0] mem_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q;
  logic              pop, full, push_ok, drop;
  logic              overflow_q;

  assign capture = i_en & i_din_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    push    = 1'b0;
`ifdef DESERIALIZER_PARITY_EN
    perr_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          shift_d[0] = i_din;
          cnt_d      = CW'(1);
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!i_din_valid) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (i_en) begin
          for (int k = 1; k < LENGTH; k++) begin
            if (cnt_q == CW'(k)) shift_d[k] = i_din;
          end
          if (cnt_q == CW'(LENGTH - 1)) begin
            cnt_d = '0;
`ifdef DESERIALIZER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_IDLE;
            push    = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef DESERIALIZER_PARITY_EN
      S_PARITY: begin
        if (!i_din_valid) begin
          state_d = S_IDLE;
        end else if (i_en) begin
          state_d = S_IDLE;
          // Even parity: data ones plus the parity bit must total an even count.
          if ((^shift_q ^ i_din) == 1'b0) push   = 1'b1;
          else                            perr_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    push_word = shift_d;
  end

  assign pop     = (count_q != 2'd0) & i_dout_ready;
  assign full    = (count_q == 2'd2);
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  // Entries are cleared on reset so the output reads zero until the first word lands.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_word;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

`ifdef DESERIALIZER_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) perr_q <= 1'b0;
    else       perr_q <= perr_d;
  end
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

  assign ov_dout      = mem_q[rd_ptr_q];
  assign o_dout_valid = (count_q != 2'd0);
  assign o_overflow   = overflow_q;

endmodule
